pipe_ctrl_unit: RTL and testbench

- Pipelined successor to the single-cycle combinational controller.
- Decodes the ID-stage instruction into a control word and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Resolves branches in EX, detects load-use hazards (stall) and taken branches (flush), and generates EX-stage forwarding selects for the 5-stage datapath.

---
 rtl/pipe_ctrl_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// EX branch resolution, load-use stall and EX forwarding selects.
module pipe_ctrl_unit #(
  parameter int REG_AW    = 5,
  parameter int ALUOP_W   = 3,
  parameter int HAZARD_EN = 1,
  parameter int FWD_EN    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic [REG_AW-1:0]  rs,
  input  logic [REG_AW-1:0]  rt,
  input  logic [REG_AW-1:0]  rd,
  input  logic               zero_ex,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_sgn_zero,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_mem_to_reg,
  output logic               wb_reg_write,
  output logic [REG_AW-1:0]  wb_dst,
  output logic               pc_src,
  output logic               flush,
  output logic               stall,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               illegal_ex
);

  localparam logic [5:0] OP_R     = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SLTU = 6'd43;

  localparam logic [ALUOP_W-1:0] AL_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AL_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AL_AND  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AL_OR   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AL_XOR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] AL_SLT  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] AL_SLTU = ALUOP_W'(7);

  typedef struct packed {
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               sgn_zero;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic               branch;
    logic               bne;
    logic               illegal;
    logic [REG_AW-1:0]  dst;
  } id_ex_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic [REG_AW-1:0] dst;
  } ex_mem_t;

  typedef struct packed {
    logic              mem_to_reg;
    logic              reg_write;
    logic [REG_AW-1:0] dst;
  } mem_wb_t;

  id_ex_t            dec;
  id_ex_t            id_ex;
  ex_mem_t           ex_mem;
  mem_wb_t           mem_wb;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              reads_rt;
  logic              stall_raw;
  logic              bubble;

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (op == OP_R): begin
        dec.reg_write = 1'b1;
        dec.dst       = rd;
        unique case (func)
          FN_ADD, FN_ADDU: dec.alu_op = AL_ADD;
          FN_SUB, FN_SUBU: dec.alu_op = AL_SUB;
          FN_AND:          dec.alu_op = AL_AND;
          FN_OR:           dec.alu_op = AL_OR;
          FN_XOR:          dec.alu_op = AL_XOR;
          FN_SLT:          dec.alu_op = AL_SLT;
          FN_SLTU:         dec.alu_op = AL_SLTU;
          default: begin
            dec         = '0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      (op == OP_LW): begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.dst        = rt;
      end
      (op == OP_SW): begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.dst       = rt;
      end
      (op == OP_BEQ),
      (op == OP_BNE): begin
        dec.alu_op = AL_SUB;
        dec.branch = 1'b1;
        dec.bne    = (op == OP_BNE);
        dec.dst    = rt;
      end
      (op == OP_ADDI),
      (op == OP_ADDIU),
      (op == OP_SLTI),
      (op == OP_SLTIU),
      (op == OP_ANDI),
      (op == OP_ORI),
      (op == OP_XORI): begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.dst       = rt;
        dec.sgn_zero  = (op == OP_ANDI) || (op == OP_ORI) ||
                        (op == OP_XORI);
        unique case (1'b1)
          (op == OP_SLTI):  dec.alu_op = AL_SLT;
          (op == OP_SLTIU): dec.alu_op = AL_SLTU;
          (op == OP_ANDI):  dec.alu_op = AL_AND;
          (op == OP_ORI):   dec.alu_op = AL_OR;
          (op == OP_XORI):  dec.alu_op = AL_XOR;
          default:          dec.alu_op = AL_ADD;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign reads_rt = (op == OP_R) || (op == OP_SW) ||
                    (op == OP_BEQ) || (op == OP_BNE);

  assign pc_src = id_ex.branch & (id_ex.bne ? ~zero_ex : zero_ex);
  assign flush  = pc_src;

  generate
    if (HAZARD_EN != 0) begin : g_hazard
      assign stall_raw = id_ex.mem_read && (id_ex.dst != '0) &&
                         ((id_ex.dst == rs) ||
                          ((id_ex.dst == rt) && reads_rt));
    end else begin : g_no_hazard
      assign stall_raw = 1'b0;
    end
  endgenerate

  // A taken branch kills the ID instruction, so its hazard is moot.
  assign stall  = stall_raw & ~flush;
  assign bubble = stall | flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
      ex_rs  <= '0;
      ex_rt  <= '0;
    end else begin
      id_ex  <= bubble ? '0 : dec;
      ex_rs  <= bubble ? '0 : rs;
      ex_rt  <= bubble ? '0 : rt;
      ex_mem <= '{mem_read:   id_ex.mem_read,
                  mem_write:  id_ex.mem_write,
                  mem_to_reg: id_ex.mem_to_reg,
                  reg_write:  id_ex.reg_write,
                  dst:        id_ex.dst};
      mem_wb <= '{mem_to_reg: ex_mem.mem_to_reg,
                  reg_write:  ex_mem.reg_write,
                  dst:        ex_mem.dst};
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              m_we,
    input logic [REG_AW-1:0] m_dst,
    input logic              w_we,
    input logic [REG_AW-1:0] w_dst
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && (m_dst != '0) && (m_dst == src))
      sel = 2'b10;
    else if (w_we && (w_dst != '0) && (w_dst == src))
      sel = 2'b01;
    return sel;
  endfunction

  generate
    if (FWD_EN != 0) begin : g_fwd
      assign fwd_a = fwd_sel(ex_rs, ex_mem.reg_write, ex_mem.dst,
                             mem_wb.reg_write, mem_wb.dst);
      assign fwd_b = fwd_sel(ex_rt, ex_mem.reg_write, ex_mem.dst,
                             mem_wb.reg_write, mem_wb.dst);
    end else begin : g_no_fwd
      assign fwd_a = 2'b00;
      assign fwd_b = 2'b00;
    end
  endgenerate

  assign ex_alu_src    = id_ex.alu_src;
  assign ex_alu_op     = id_ex.alu_op;
  assign ex_sgn_zero   = id_ex.sgn_zero;
  assign illegal_ex    = id_ex.illegal;
  assign mem_read      = ex_mem.mem_read;
  assign mem_write     = ex_mem.mem_write;
  assign wb_mem_to_reg = mem_wb.mem_to_reg;
  assign wb_reg_write  = mem_wb.reg_write;
  assign wb_dst        = mem_wb.dst;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: directed instruction stream,
// expectations queued per cycle, checked by an independent monitor.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, func;
  logic [4:0] rs, rt, rd;
  logic       zero_ex;
  logic       ex_alu_src;
  logic [2:0] ex_alu_op;
  logic       ex_sgn_zero;
  logic       mem_read, mem_write;
  logic       wb_mem_to_reg, wb_reg_write;
  logic [4:0] wb_dst;
  logic       pc_src, flush, stall;
  logic [1:0] fwd_a, fwd_b;
  logic       illegal_ex;

  pipe_ctrl_unit dut (
    .clk(clk), .rst(rst), .op(op), .func(func),
    .rs(rs), .rt(rt), .rd(rd), .zero_ex(zero_ex),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_sgn_zero(ex_sgn_zero), .mem_read(mem_read),
    .mem_write(mem_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
    .pc_src(pc_src), .flush(flush), .stall(stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal_ex(illegal_ex)
  );

  always #5 clk = ~clk;

  typedef enum {
    F_EX_SRC, F_EX_OP, F_SGN, F_MRD, F_MWR, F_WB_M2R, F_WB_RW,
    F_WB_DST, F_PC, F_FLUSH, F_STALL, F_FWDA, F_FWDB, F_ILL
  } fld_e;

  typedef struct {
    int   cyc;
    fld_e f;
    int   v;
    int   t;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   tnum = 0;
  bit   done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int act(fld_e f);
    case (f)
      F_EX_SRC: return int'(ex_alu_src);
      F_EX_OP:  return int'(ex_alu_op);
      F_SGN:    return int'(ex_sgn_zero);
      F_MRD:    return int'(mem_read);
      F_MWR:    return int'(mem_write);
      F_WB_M2R: return int'(wb_mem_to_reg);
      F_WB_RW:  return int'(wb_reg_write);
      F_WB_DST: return int'(wb_dst);
      F_PC:     return int'(pc_src);
      F_FLUSH:  return int'(flush);
      F_STALL:  return int'(stall);
      F_FWDA:   return int'(fwd_a);
      F_FWDB:   return int'(fwd_b);
      default:  return int'(illegal_ex);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc || done) begin
        nchk++;
        if (sb[i].cyc != cyc || act(sb[i].f) != sb[i].v) begin
          nerr++;
          $display("FAIL t%0d %s cyc=%0d/%0d got=%0d exp=%0d",
                   sb[i].t, sb[i].f.name(), cyc, sb[i].cyc,
                   act(sb[i].f), sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  task automatic exp_at(input int off, input fld_e f, input int v);
    sb.push_back('{cyc + off, f, v, tnum});
  endtask

  task automatic chk_reset;
    nchk++;
    if (ex_alu_src !== 1'b0 || ex_alu_op !== 3'd0 ||
        ex_sgn_zero !== 1'b0 || mem_read !== 1'b0 ||
        mem_write !== 1'b0 || wb_mem_to_reg !== 1'b0 ||
        wb_reg_write !== 1'b0 || wb_dst !== 5'd0 ||
        pc_src !== 1'b0 || flush !== 1'b0 || stall !== 1'b0 ||
        fwd_a !== 2'b00 || fwd_b !== 2'b00 ||
        illegal_ex !== 1'b0) begin
      nerr++;
      $display("FAIL t%0d reset state not all zero", tnum);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [5:0] fn,
                       input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic z);
    op = o; func = fn; rs = s; rt = t; rd = d; zero_ex = z;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) begin
      drive(6'd0, 6'd32, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
    end
  endtask

  typedef struct {
    logic [5:0] o;
    logic [5:0] fn;
    int         alu;
    int         src;
    int         sgn;
  } dec_t;

  dec_t dtab[$] = '{
    '{6'd0, 6'd32, 0, 0, 0}, '{6'd0, 6'd33, 0, 0, 0},
    '{6'd0, 6'd34, 1, 0, 0}, '{6'd0, 6'd35, 1, 0, 0},
    '{6'd0, 6'd36, 2, 0, 0}, '{6'd0, 6'd37, 3, 0, 0},
    '{6'd0, 6'd38, 4, 0, 0}, '{6'd0, 6'd42, 6, 0, 0},
    '{6'd0, 6'd43, 7, 0, 0}, '{6'd35, 6'd0, 0, 1, 0},
    '{6'd43, 6'd0, 0, 1, 0}, '{6'd8, 6'd0, 0, 1, 0},
    '{6'd9, 6'd0, 0, 1, 0},  '{6'd10, 6'd0, 6, 1, 0},
    '{6'd11, 6'd0, 7, 1, 0}, '{6'd12, 6'd0, 2, 1, 1},
    '{6'd13, 6'd0, 3, 1, 1}, '{6'd14, 6'd0, 4, 1, 1}
  };

  initial begin
    rst = 1'b1;
    drive(6'd0, 6'd32, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    chk_reset();
    rst = 1'b0;

    tnum = 1;
    exp_at(0, F_EX_OP, 0);  exp_at(0, F_EX_SRC, 0);
    exp_at(0, F_MRD, 0);    exp_at(0, F_MWR, 0);
    exp_at(0, F_WB_RW, 0);  exp_at(0, F_WB_DST, 0);
    exp_at(0, F_PC, 0);     exp_at(0, F_STALL, 0);
    exp_at(0, F_FWDA, 0);   exp_at(0, F_ILL, 0);
    nop(1);

    tnum = 2;
    drive(6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 1'b0);
    exp_at(1, F_EX_OP, 0);  exp_at(1, F_EX_SRC, 0);
    exp_at(3, F_WB_RW, 1);  exp_at(3, F_WB_DST, 3);
    exp_at(3, F_WB_M2R, 0);
    tick();
    nop(3);

    tnum = 3;
    for (int i = 0; i < dtab.size(); i++) begin
      drive(dtab[i].o, dtab[i].fn, 5'd0, 5'd0, 5'd0, 1'b0);
      exp_at(1, F_EX_OP, dtab[i].alu);
      exp_at(1, F_EX_SRC, dtab[i].src);
      exp_at(1, F_SGN, dtab[i].sgn);
      tick();
    end
    nop(3);

    tnum = 4;
    drive(6'd35, 6'd0, 5'd1, 5'd4, 5'd0, 1'b0);
    exp_at(2, F_MRD, 1);
    tick();
    drive(6'd0, 6'd34, 5'd4, 5'd2, 5'd6, 1'b0);
    exp_at(0, F_STALL, 1);  exp_at(0, F_FLUSH, 0);
    tick();
    exp_at(0, F_STALL, 0);  exp_at(0, F_EX_OP, 0);
    exp_at(1, F_EX_OP, 1);  exp_at(1, F_FWDA, 1);
    exp_at(1, F_FWDB, 0);   exp_at(1, F_WB_M2R, 1);
    exp_at(1, F_WB_DST, 4);
    tick();
    nop(3);

    tnum = 5;
    drive(6'd35, 6'd0, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    drive(6'd8, 6'd0, 5'd1, 5'd4, 5'd0, 1'b0);
    exp_at(0, F_STALL, 0);
    tick();
    drive(6'd35, 6'd0, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    drive(6'd0, 6'd32, 5'd0, 5'd0, 5'd7, 1'b0);
    exp_at(0, F_STALL, 0);
    tick();
    drive(6'd35, 6'd0, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    drive(6'd43, 6'd0, 5'd2, 5'd4, 5'd0, 1'b0);
    exp_at(0, F_STALL, 1);
    tick();
    exp_at(0, F_STALL, 0);
    tick();
    nop(3);

    tnum = 6;
    drive(6'd4, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    exp_at(1, F_PC, 1);     exp_at(1, F_FLUSH, 1);
    exp_at(1, F_EX_OP, 1);  exp_at(1, F_EX_SRC, 0);
    exp_at(2, F_EX_OP, 0);  exp_at(2, F_SGN, 0);
    tick();
    drive(6'd13, 6'd0, 5'd1, 5'd7, 5'd0, 1'b1);
    exp_at(0, F_STALL, 0);
    tick();
    nop(2);

    tnum = 7;
    drive(6'd4, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(6'd13, 6'd0, 5'd1, 5'd7, 5'd0, 1'b0);
    exp_at(0, F_PC, 0);     exp_at(0, F_FLUSH, 0);
    exp_at(1, F_EX_OP, 3);  exp_at(1, F_SGN, 1);
    exp_at(1, F_EX_SRC, 1);
    tick();
    nop(2);

    tnum = 8;
    drive(6'd5, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(6'd13, 6'd0, 5'd1, 5'd7, 5'd0, 1'b0);
    exp_at(0, F_PC, 1);     exp_at(0, F_FLUSH, 1);
    exp_at(1, F_EX_OP, 0);
    tick();
    nop(2);
    drive(6'd5, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(6'd13, 6'd0, 5'd1, 5'd7, 5'd0, 1'b1);
    exp_at(0, F_PC, 0);     exp_at(0, F_FLUSH, 0);
    exp_at(1, F_EX_OP, 3);
    tick();
    nop(3);

    tnum = 9;
    drive(6'd0, 6'd32, 5'd1, 5'd2, 5'd5, 1'b0);
    tick();
    drive(6'd0, 6'd34, 5'd5, 5'd3, 5'd8, 1'b0);
    exp_at(1, F_FWDA, 2);   exp_at(1, F_FWDB, 0);
    tick();
    nop(3);

    tnum = 10;
    drive(6'd0, 6'd32, 5'd1, 5'd2, 5'd5, 1'b0);
    tick();
    nop(1);
    drive(6'd0, 6'd34, 5'd5, 5'd3, 5'd8, 1'b0);
    exp_at(1, F_FWDA, 1);
    tick();
    nop(3);

    tnum = 11;
    drive(6'd0, 6'd32, 5'd1, 5'd2, 5'd5, 1'b0);
    tick();
    drive(6'd8, 6'd0, 5'd1, 5'd5, 5'd0, 1'b0);
    tick();
    drive(6'd0, 6'd34, 5'd5, 5'd5, 5'd8, 1'b0);
    exp_at(1, F_FWDA, 2);   exp_at(1, F_FWDB, 2);
    tick();
    nop(3);

    tnum = 12;
    drive(6'd0, 6'd32, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(6'd0, 6'd34, 5'd0, 5'd0, 5'd8, 1'b0);
    exp_at(1, F_FWDA, 0);   exp_at(1, F_FWDB, 0);
    tick();
    nop(3);

    tnum = 13;
    drive(6'd8, 6'd0, 5'd1, 5'd9, 5'd0, 1'b0);
    tick();
    drive(6'd43, 6'd0, 5'd2, 5'd9, 5'd0, 1'b0);
    exp_at(1, F_FWDB, 2);   exp_at(1, F_FWDA, 0);
    exp_at(2, F_MWR, 1);    exp_at(3, F_WB_RW, 0);
    tick();
    nop(3);

    tnum = 14;
    drive(6'd63, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
    exp_at(1, F_ILL, 1);    exp_at(1, F_EX_OP, 0);
    exp_at(2, F_ILL, 0);    exp_at(2, F_MWR, 0);
    exp_at(3, F_WB_RW, 0);
    tick();
    nop(2);
    drive(6'd0, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
    exp_at(1, F_ILL, 1);    exp_at(3, F_WB_RW, 0);
    tick();
    nop(3);

    tnum = 15;
    drive(6'd0, 6'd32, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    drive(6'd35, 6'd0, 5'd1, 5'd4, 5'd0, 1'b0);
    tick();
    drive(6'd0, 6'd34, 5'd4, 5'd2, 5'd6, 1'b0);
    exp_at(0, F_STALL, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_at(0, F_STALL, 0);  exp_at(0, F_PC, 0);
    exp_at(0, F_MRD, 0);    exp_at(0, F_MWR, 0);
    exp_at(0, F_EX_OP, 0);  exp_at(0, F_WB_RW, 0);
    exp_at(0, F_WB_DST, 0); exp_at(0, F_FWDA, 0);
    drive(6'd0, 6'd32, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk_reset();
    tick();
    nop(3);

    for (int i = 0; i < 12 && sb.size() != 0; i++) nop(1);
    nchk++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL expired wait: %0d pending", sb.size());
    end
    done = 1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
